maj_fold_checker: RTL and testbench

- Sequential checker placed directly downstream of the 45-input combinational majority block (`top`, inputs x0..x44, output y0).
- Captures each applied input vector together with the DUT's y0 result.
- Recomputes the reference majority by folding the popcount over CHUNK bits per cycle, then reports match/mismatch on a valid/ready result channel.
- Keeps running sample and mismatch counters, so mapped netlists can be self-checked in simulation or on an FPGA without a behavioural reference.

---
 rtl/maj_pkg.sv | 20 ++
 rtl/maj_chunk_popcount.sv | 21 ++
 rtl/maj_fold_checker.sv | 112 +++++++++++
 tb/tb_maj_fold_checker.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/maj_pkg.sv
// Shared constants and state encoding for the majority fold checker.
// The checker folds a popcount over CHUNK-bit slices to build a reference majority.
package maj_pkg;

  localparam int N      = 45;
  localparam int CHUNK  = 5;
  localparam int THRESH = (N + 1) / 2;
  localparam int NCH    = (N + CHUNK - 1) / CHUNK;
  localparam int PW     = NCH * CHUNK;
  localparam int CW     = $clog2(N + 1);
  localparam int SW     = $clog2(CHUNK + 1);
  localparam int IW     = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

endpackage

// File: rtl/maj_chunk_popcount.sv
// Combinational popcount of one CHUNK-bit slice.
// Bits whose absolute position is N or higher are padding and count as zero.
module maj_chunk_popcount
  import maj_pkg::*;
(
  input  logic [CHUNK-1:0] bits,
  input  logic [IW-1:0]    chunk_idx,
  output logic [SW-1:0]    sum
);

  // NOTE: give every always_comb output a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    sum = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (int'(chunk_idx) * CHUNK + i < N) begin
        sum = sum + SW'(bits[i]);
      end
    end
  end

endmodule

// File: rtl/maj_fold_checker.sv
// Captures a majority-block input vector and its y0 result, recomputes the majority
// CHUNK bits per cycle, and reports match/mismatch with saturating statistics.
module maj_fold_checker
  import maj_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_x,
  input  logic          in_y,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [CW-1:0] res_count,
  output logic          res_ref,
  output logic          res_match,
  output logic [31:0]   sample_cnt,
  output logic [15:0]   mismatch_cnt
);

  state_t state, state_next;

  logic [PW-1:0]    x_shadow;
  logic             y_shadow;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    acc;
  logic [CHUNK-1:0] chunk_bits;
  logic [SW-1:0]    chunk_sum;
  logic [CW-1:0]    sum_next;
  logic             ref_next;
  logic             last_chunk;
  logic             accept;
  logic             handoff;

  assign in_ready   = (state == IDLE);
  assign res_valid  = (state == DONE);
  assign accept     = in_valid && in_ready;
  assign handoff    = res_valid && res_ready;
  assign last_chunk = (idx == IW'(NCH - 1));

  // The shadow is padded to NCH*CHUNK bits so the last slice never reads out of range.
  assign chunk_bits = x_shadow[int'(idx) * CHUNK +: CHUNK];
  assign sum_next   = acc + CW'(chunk_sum);
  assign ref_next   = (sum_next >= CW'(THRESH));

  maj_chunk_popcount u_popcount (
    .bits      (chunk_bits),
    .chunk_idx (idx),
    .sum       (chunk_sum)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept)     state_next = ACC;
      ACC:     if (last_chunk) state_next = DONE;
      DONE:    if (res_ready)  state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // NOTE: the shadow registers are reset too, so no output or internal value is ever X after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_shadow  <= '0;
      y_shadow  <= 1'b0;
      idx       <= '0;
      acc       <= '0;
      res_count <= '0;
      res_ref   <= 1'b0;
      res_match <= 1'b0;
    end else if (accept) begin
      x_shadow <= PW'(in_x);
      y_shadow <= in_y;
      idx      <= '0;
      acc      <= '0;
    end else if (state == ACC) begin
      acc <= sum_next;
      idx <= idx + IW'(1);
      if (last_chunk) begin
        res_count <= sum_next;
        res_ref   <= ref_next;
        res_match <= (y_shadow == ref_next);
      end
    end
  end

  // Clear takes priority over a coinciding handoff, so that result goes uncounted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt   <= '0;
      mismatch_cnt <= '0;
    end else if (clear) begin
      sample_cnt   <= '0;
      mismatch_cnt <= '0;
    end else if (handoff) begin
      if (sample_cnt != '1) sample_cnt <= sample_cnt + 32'd1;
      if (!res_match && mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_maj_fold_checker.sv
// Self-checking bench for maj_fold_checker: table-driven vectors through a scoreboard
// queue plus hand-written backpressure, mid-flight reset and clear sequences.
module tb_maj_fold_checker;
  import maj_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_x;
  logic          in_y;
  logic          res_valid;
  logic          res_ready;
  logic [CW-1:0] res_count;
  logic          res_ref;
  logic          res_match;
  logic [31:0]   sample_cnt;
  logic [15:0]   mismatch_cnt;

  always #5 clk = ~clk;

  maj_fold_checker dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_x         (in_x),
    .in_y         (in_y),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_count    (res_count),
    .res_ref      (res_ref),
    .res_match    (res_match),
    .sample_cnt   (sample_cnt),
    .mismatch_cnt (mismatch_cnt)
  );

  typedef struct {
    logic [N-1:0]  x;
    logic          y;
    logic [CW-1:0] count;
    logic          rref;
    logic          match;
  } vec_t;

  typedef struct {
    logic [CW-1:0] count;
    logic          rref;
    logic          match;
  } exp_t;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned exp_samples = 0;
  int unsigned exp_mism = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [N-1:0] x, input logic y);
    exp_t e;
    int   c;
    c       = $countones(x);
    e.count = CW'(c);
    e.rref  = (c >= THRESH);
    e.match = (y == e.rref);
    return e;
  endfunction

  task automatic send(input logic [N-1:0] x, input logic y, input exp_t e);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 64'd0, 64'd1);
      return;
    end
    in_x = x;
    in_y = y;
    in_valid = 1'b1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!res_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!res_valid) check("res_valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic collect(input string tag, input logic do_clear);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_count"}, 64'(res_count), 64'(e.count));
    check({tag, "_ref"},   64'(res_ref),   64'(e.rref));
    check({tag, "_match"}, 64'(res_match), 64'(e.match));
    res_ready = 1'b1;
    clear     = do_clear;
    @(posedge clk);
    if (do_clear) begin
      exp_samples = 0;
      exp_mism    = 0;
    end else begin
      exp_samples++;
      if (!e.match) exp_mism++;
    end
    #1;
    res_ready = 1'b0;
    clear     = 1'b0;
    check({tag, "_valid_drop"}, 64'(res_valid), 64'd0);
    check({tag, "_in_ready"},   64'(in_ready),  64'd1);
    check({tag, "_samples"},    64'(sample_cnt),   64'(exp_samples));
    check({tag, "_mismatch"},   64'(mismatch_cnt), 64'(exp_mism));
  endtask

  initial begin
    vec_t vecs[7];
    int   lat;
    exp_t e;
    logic [CW-1:0] snap_count;
    logic          snap_ref, snap_match, stable;
    logic [31:0]   snap_samples;

    vecs[0] = '{45'h0,            1'b0, 6'd0,  1'b0, 1'b1};
    vecs[1] = '{45'h7FFFFF,       1'b1, 6'd23, 1'b1, 1'b1};
    vecs[2] = '{45'h3FFFFF,       1'b1, 6'd22, 1'b0, 1'b0};
    vecs[3] = '{45'h1FFFFFFFFFFF, 1'b1, 6'd45, 1'b1, 1'b1};
    vecs[4] = '{45'h1FFFFFC00000, 1'b0, 6'd23, 1'b1, 1'b0};
    vecs[5] = '{45'h0AAAAAAAAAAA, 1'b0, 6'd22, 1'b0, 1'b1};
    vecs[6] = '{45'h100000000000, 1'b0, 6'd1,  1'b0, 1'b1};

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_x = '0; in_y = 1'b0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_count",     64'(res_count), 64'd0);
    check("rst_ref_match", 64'({res_ref, res_match}), 64'd0);
    check("rst_counters",  64'({sample_cnt, mismatch_cnt}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table: zero vector, threshold boundaries, all ones, high bits, alternating, single bit.
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].x, vecs[i].y, '{vecs[i].count, vecs[i].rref, vecs[i].match});
      wait_valid(lat);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(NCH));
      collect($sformatf("vec%0d", i), 1'b0);
    end

    // Backpressure: hold DONE for 20 cycles while a stray in_valid is presented.
    send(45'h155555555555, 1'b1, model(45'h155555555555, 1'b1));
    wait_valid(lat);
    snap_count = res_count; snap_ref = res_ref; snap_match = res_match;
    snap_samples = sample_cnt;
    stable = 1'b1;
    in_x = 45'h1F; in_y = 1'b0; in_valid = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (!res_valid || in_ready || res_count !== snap_count || res_ref !== snap_ref ||
          res_match !== snap_match || sample_cnt !== snap_samples) stable = 1'b0;
    end
    in_valid = 1'b0;
    check("bp_stable", 64'(stable), 64'd1);
    collect("bp", 1'b0);
    @(posedge clk); #1;
    check("bp_stray_ignored", 64'({in_ready, res_valid}), 64'b10);

    // Reset asserted during the 4th accumulate cycle discards the sample.
    send(45'h1FFFFFFFFFFF, 1'b1, model(45'h1FFFFFFFFFFF, 1'b1));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready",  64'(in_ready),  64'd1);
    check("midrst_res_valid", 64'(res_valid), 64'd0);
    check("midrst_outputs",   64'({res_count, res_ref, res_match}), 64'd0);
    check("midrst_counters",  64'({sample_cnt, mismatch_cnt}), 64'd0);
    sb_q.delete();
    exp_samples = 0;
    exp_mism    = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(45'h1F, 1'b0, '{6'd5, 1'b0, 1'b1});
    wait_valid(lat);
    check("postrst_latency", 64'(lat), 64'(NCH));
    collect("postrst", 1'b0);

    // Clear coinciding with a mismatching handoff wins.
    send(45'h3FFFFF, 1'b1, '{6'd22, 1'b0, 1'b0});
    wait_valid(lat);
    collect("clr", 1'b1);
    send(45'h0, 1'b0, '{6'd0, 1'b0, 1'b1});
    wait_valid(lat);
    collect("after_clr", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
